// File: rtl/hpu_seq_ctrl.sv
// HPU sequence controller: optional generation phase, counted get stream,
// bounded drain window for the end-of-stream pulse, then a one-cycle DONE.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// GEN   | generation phase, down-counter paces gen_cycles cycles
// RUN   | counting accepted get words until word_count is reached
// DRAIN | all words seen, waiting up to DRAIN_MAX cycles for get_fin
// DONE  | one-cycle completion pulse, back to IDLE
module hpu_seq_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             gen_req,
    input  logic [CNT_W-1:0] gen_cycles,
    input  logic [CNT_W-1:0] word_count,
    input  logic             get_v,
    input  logic             get_fin,
    output logic             gen,
    output logic             run,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] rcv_count
);

    localparam int DW = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL_ONES   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_gen_cnt;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_rcv;
    logic [DW-1:0]    r_drain_cnt;
    logic             r_err;

    logic w_gen_last;
    logic w_last_word;
    logic w_drain_last;

    assign w_gen_last   = (r_gen_cnt <= ONE);
    assign w_last_word  = get_v && (r_rcv == (r_word_cnt - ONE));
    assign w_drain_last = (r_drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // abort is checked first in every active state so it wins over all else
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (gen_req && (gen_cycles != '0)) begin
                        w_next = S_GEN;
                    end else if (word_count != '0) begin
                        w_next = S_RUN;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_GEN: begin
                if (abort) begin
                    w_next = S_DONE;
                end else if (w_gen_last) begin
                    w_next = (r_word_cnt != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort || get_fin) begin
                    w_next = S_DONE;
                end else if (w_last_word) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort || get_fin || w_drain_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        gen  = 1'b0;
        run  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_GEN: begin
                gen  = 1'b1;
                run  = 1'b1;
                busy = 1'b1;
            end
            S_RUN, S_DRAIN: begin
                run  = 1'b1;
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gen_cnt   <= '0;
            r_word_cnt  <= '0;
            r_rcv       <= '0;
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_gen_cnt  <= gen_req ? gen_cycles : '0;
                        r_word_cnt <= word_count;
                        r_rcv      <= '0;
                        r_err      <= 1'b0;
                    end
                end
                S_GEN: begin
                    if (abort) begin
                        r_err     <= 1'b1;
                        r_gen_cnt <= '0;
                    end else if (r_gen_cnt != '0) begin
                        r_gen_cnt <= r_gen_cnt - ONE;
                    end
                end
                S_RUN: begin
                    r_drain_cnt <= '0;
                    if (abort) begin
                        r_err <= 1'b1;
                    end else begin
                        if (get_v && (r_rcv != ALL_ONES)) begin
                            r_rcv <= r_rcv + ONE;
                        end
                        if (get_fin) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + DW'(1);
                    if (abort) begin
                        r_err <= 1'b1;
                    end else if (get_v || (w_drain_last && !get_fin)) begin
                        // overrun word, or the drain window expired
                        r_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_gen_cnt   <= '0;
                    r_drain_cnt <= '0;
                end
                default: begin
                    r_gen_cnt <= '0;
                end
            endcase
        end
    end

    assign err       = r_err;
    assign rcv_count = r_rcv;

endmodule
